// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Double-dabble correction: a digit >= 5 would carry past 9 after doubling.
    function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit pre-shift adjustment (add 3 when the digit is 5 or more).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q_c
);

    assign q_c = add3_if_ge5(d);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with overflow detection and a leading-zero blanking mask for the display.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      ovf,
    output logic [DIGITS-1:0]         blank
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   work, work_nxt;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;
    logic [BIN_W-1:0]   sreg, sreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               sticky, sticky_nxt;
    logic [BCD_W-1:0]   bcd_nxt;
    logic               ovf_nxt;
    logic               done_nxt;
    logic               busy_nxt;
    logic [DIGITS-1:0]  blank_nxt;
    logic [DIGITS-1:0]  blank_shift;
    logic               lz;

    // Per-digit add-3 correction, all digits in parallel ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d   (work[g*DIGIT_W +: DIGIT_W]),
            .q_c (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted = {adj[BCD_W-2:0], sreg[BIN_W-1]};

    // Leading-zero mask of the post-shift digits; the units digit is never blanked.
    always_comb begin
        blank_shift = '0;
        lz          = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz             = lz & (shifted[i*DIGIT_W +: DIGIT_W] == '0);
            blank_shift[i] = lz;
        end
    end

    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        sreg_nxt   = sreg;
        cnt_nxt    = cnt;
        sticky_nxt = sticky;
        bcd_nxt    = bcd;
        ovf_nxt    = ovf;
        blank_nxt  = blank;
        done_nxt   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sreg_nxt   = bin;
                    work_nxt   = '0;
                    sticky_nxt = 1'b0;
                    cnt_nxt    = CNT_W'(BIN_W);
                    state_nxt  = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                // The bit leaving the top digit means the value exceeds the digit range.
                work_nxt   = shifted;
                sreg_nxt   = {sreg[BIN_W-2:0], 1'b0};
                sticky_nxt = sticky | adj[BCD_W-1];
                cnt_nxt    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bcd_nxt   = shifted;
                    ovf_nxt   = sticky | adj[BCD_W-1];
                    blank_nxt = blank_shift;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            sreg   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
            blank  <= BLANK_RST;
            done   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b1;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            sreg   <= sreg_nxt;
            cnt    <= cnt_nxt;
            sticky <= sticky_nxt;
            bcd    <= bcd_nxt;
            ovf    <= ovf_nxt;
            blank  <= blank_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
            ready  <= !busy_nxt;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq across three parameter sets
// (16b/5 digits, 16b/4 digits, 8b/3 digits).
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    logic        rst0, start0, ready0, busy0, done0, ovf0;
    logic [15:0] bin0;
    logic [19:0] bcd0;
    logic [4:0]  blank0;

    logic        rst1, start1, ready1, busy1, done1, ovf1;
    logic [15:0] bin1;
    logic [15:0] bcd1;
    logic [3:0]  blank1;

    logic        rst2, start2, ready2, busy2, done2, ovf2;
    logic [7:0]  bin2;
    logic [11:0] bcd2;
    logic [2:0]  blank2;

    bin_to_bcd_seq u0 (
        .clk(clk), .rst(rst0), .start(start0), .bin(bin0), .ready(ready0),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0), .blank(blank0)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .bin(bin1), .ready(ready1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1), .blank(blank1)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .bin(bin2), .ready(ready2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2), .blank(blank2)
    );

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic mon_check(input string tag, input exp_t e, input logic [19:0] b,
                             input logic o, input logic [4:0] bl);
        chk({tag, "_bcd"},     32'(b),  32'(e.bcd));
        chk({tag, "_ovf"},     32'(o),  32'(e.ovf));
        chk({tag, "_blank"},   32'(bl), 32'(e.blank));
        chk({tag, "_latency"}, cyc,     e.cyc);
    endtask

    // Monitors: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL u0_unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                e0 = q0.pop_front();
                mon_check("u0", e0, bcd0, ovf0, blank0);
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL u1_unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                e1 = q1.pop_front();
                mon_check("u1", e1, 20'(bcd1), ovf1, 5'(blank1));
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                $display("FAIL u2_unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                e2 = q2.pop_front();
                mon_check("u2", e2, 20'(bcd2), ovf2, 5'(blank2));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present start for one edge; expected done lands BIN_W cycles after the accepting edge.
    task automatic issue(input int sel, input logic [15:0] v, input logic [19:0] eb,
                         input logic eo, input logic [4:0] ebl, input bit push, input bit hold);
        exp_t e;
        logic [31:0] w;
        case (sel)
            0: begin bin0 = v;      start0 = 1'b1; end
            1: begin bin1 = v;      start1 = 1'b1; end
            default: begin bin2 = v[7:0]; start2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        w = (sel == 2) ? 32'd8 : 32'd16;
        e = '{bcd: eb, ovf: eo, blank: ebl, cyc: cyc + w};
        if (push) begin
            case (sel)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        // Scramble the input while busy; it must not affect the result.
        case (sel)
            0: begin bin0 = ~v;      start0 = hold; end
            1: begin bin1 = ~v;      start1 = hold; end
            default: begin bin2 = ~v[7:0]; start2 = hold; end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0 = '0; bin1 = '0; bin2 = '0;
        wait_cyc(3);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        chk("rst_ready",  32'(ready0), 32'd1);
        chk("rst_busy",   32'(busy0),  32'd0);
        chk("rst_done",   32'(done0),  32'd0);
        chk("rst_bcd",    32'(bcd0),   32'd0);
        chk("rst_ovf",    32'(ovf0),   32'd0);
        chk("rst_blank",  32'(blank0), 32'b11110);
        chk("rst_blank1", 32'(blank1), 32'b1110);
        chk("rst_blank2", 32'(blank2), 32'b110);

        // 2578 with default parameters, plus busy duration
        issue(0, 16'd2578, 20'h02578, 1'b0, 5'b10000, 1'b1, 1'b0);
        n = 0;
        repeat (18) begin
            @(negedge clk);
            if (busy0 === 1'b1) n++;
        end
        chk("t1_busy_cycles", 32'(n), 32'd16);
        wait_cyc(2);

        // start mid-conversion with another value is ignored
        issue(0, 16'd9876, 20'h09876, 1'b0, 5'b10000, 1'b1, 1'b0);
        wait_cyc(4);
        bin0 = 16'd1111;
        start0 = 1'b1;
        wait_cyc(1);
        start0 = 1'b0;
        chk("t4_busy",     32'(busy0),  32'd1);
        chk("t4_ready",    32'(ready0), 32'd0);
        chk("t4_bcd_hold", 32'(bcd0),   32'h02578);
        wait_cyc(20);

        // reset mid-conversion aborts without a done pulse
        issue(0, 16'd4321, 20'h04321, 1'b0, 5'b10000, 1'b0, 1'b0);
        wait_cyc(7);
        rst0 = 1'b1;
        wait_cyc(1);
        rst0 = 1'b0;
        chk("t5_busy",  32'(busy0),  32'd0);
        chk("t5_ready", 32'(ready0), 32'd1);
        chk("t5_done",  32'(done0),  32'd0);
        chk("t5_bcd",   32'(bcd0),   32'd0);
        chk("t5_blank", 32'(blank0), 32'b11110);
        wait_cyc(20);
        issue(0, 16'd4321, 20'h04321, 1'b0, 5'b10000, 1'b1, 1'b0);
        wait_cyc(18);

        // extremes for the default configuration
        issue(0, 16'd65535, 20'h65535, 1'b0, 5'b00000, 1'b1, 1'b0);
        wait_cyc(18);
        issue(0, 16'd0, 20'h00000, 1'b0, 5'b11110, 1'b1, 1'b0);
        wait_cyc(18);

        // four digits: overflow keeps value mod 10000
        issue(1, 16'd12345, 20'h02345, 1'b1, 5'b00000, 1'b1, 1'b0);
        wait_cyc(18);
        issue(1, 16'd9999, 20'h09999, 1'b0, 5'b00000, 1'b1, 1'b0);
        wait_cyc(18);
        issue(1, 16'd10000, 20'h00000, 1'b1, 5'b01110, 1'b1, 1'b0);
        wait_cyc(18);

        // 8-bit input, three digits
        issue(2, 16'd255, 20'h00255, 1'b0, 5'b00000, 1'b1, 1'b0);
        wait_cyc(10);
        issue(2, 16'd7, 20'h00007, 1'b0, 5'b00110, 1'b1, 1'b0);
        wait_cyc(10);

        // start held high: back-to-back results every 17 cycles
        issue(0, 16'd1, 20'h00001, 1'b0, 5'b11110, 1'b1, 1'b1);
        wait_cyc(16);
        issue(0, 16'd2, 20'h00002, 1'b0, 5'b11110, 1'b1, 1'b1);
        wait_cyc(16);
        issue(0, 16'd3, 20'h00003, 1'b0, 5'b11110, 1'b1, 1'b0);
        wait_cyc(20);

        chk("u0_pending", 32'(q0.size()), 32'd0);
        chk("u1_pending", 32'(q1.size()), 32'd0);
        chk("u2_pending", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, iterative binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock.
Next generation of the fixed 16-bit, 4-digit converter:
- configurable input width and digit count
- start/busy/done handshake
- overflow flag
- leading-zero blanking mask

Sits between the arithmetic/counter datapath and the 7-segment display controller (multiplexer).

Parameters:
BIN_W, 16, binary input width in bits (>=4).
DIGITS, 5, number of BCD output digits (>=1); 5 covers all 16-bit values.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of bin; sampled only when ready=1
bin  input  BIN_W  unsigned binary value, sampled on the accepted start edge
ready  output  1  high in IDLE or DONE (start will be accepted)
busy  output  1  high while converting (SHIFT state)
done  output  1  one-cycle pulse: bcd/ovf/blank updated this cycle
bcd  output  4*DIGITS  packed digits, bits [3:0] = units, [7:4] = tens, ...
ovf  output  1  value did not fit in DIGITS digits (bcd then holds value mod 10^DIGITS)
blank  output  DIGITS  leading-zero mask, bit i=1 -> digit i is a leading zero; bit 0 always 0

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, bcd=0, ovf=0, done=0, busy=0
  - blank = all ones except bit 0 (consistent with value 0)
  - internal shift register and counter cleared
- rst dominates start. rst mid-conversion aborts it: no done pulse, outputs return to reset values on that edge.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE, start=1 at edge k:
  - load sreg = bin
  - clear working digits and overflow sticky
  - cnt = BIN_W
  - go to SHIFT
- IDLE/DONE, start=0: DONE -> IDLE; IDLE stays.
- SHIFT, each edge:
  - every working digit >= 5 gets +3 (per-digit, in parallel, before the shift)
  - then shift {digits, sreg} left by 1; MSB of sreg enters units bit 0
  - bit shifted out of the top digit sets the overflow sticky
  - cnt decrements
- Step with cnt==1 (edge k+BIN_W):
  - working digits, sticky and computed blank mask registered into bcd/ovf/blank
  - done=1, go to DONE
- Latency: start sampled at edge k -> done high in the cycle after edge k+BIN_W (BIN_W cycles).
- Throughput: start held high gives one result every BIN_W+1 cycles (start accepted in DONE).
- busy=1 exactly while in SHIFT. ready = !busy.
- start while busy is ignored; bin changes while busy have no effect.
- bcd, ovf, blank change only on a done edge or reset; held stable otherwise.
- blank[i] (i>=1) = 1 iff digits i..DIGITS-1 are all zero; blank[0]=0.
- Width rules:
  - digit add-3 is 4-bit; result of a digit >=5 is at most 12 before the shift, so no digit exceeds 9 after it
  - cnt width = clog2(BIN_W+1)

Decomposition:
- Package bcd_pkg:
  - state encoding constants (IDLE, SHIFT, DONE)
  - DIGIT_W=4
  - function add3_if_ge5(digit)
- One natural combinational sub-module, bcd_digit_adj: 4-bit in, 4-bit out (add 3 when >=5). Instantiated DIGITS times via generate.

Test Plan:
1. Defaults, bin=2578, start 1 cycle -> busy for 16 cycles; done pulses 16 cycles after start edge; bcd=0x02578, ovf=0, blank=5'b10000.
2. bin=65535 -> bcd=0x65535, ovf=0, blank=0. bin=0 -> bcd=0, blank=5'b11110.
3. DIGITS=4: bin=12345 -> ovf=1, bcd=0x2345. bin=9999 -> ovf=0, bcd=0x9999.
4. start pulsed at cycle 5 of a conversion with a different bin -> ignored; first result unchanged; single done pulse.
5. rst asserted at cycle 8 of a conversion -> next edge: IDLE, no done, bcd=0, blank reset value. A fresh start then converts correctly.
6. start held high, bin=1,2,3 sequence -> done every 17 cycles; bcd=1,2,3 in order. BIN_W=8, DIGITS=3: bin=255 -> 0x255 after 8 cycles.
